encout_apb_arb: RTL and testbench
=================================

Name: encout_apb_arb

Overview:
- APB3 master-side arbiter and sequencer for the encoder-output register block's APB slave port.
- Shares one APB3 bus between NREQ internal requesters, for example the CPU bridge and a DMA/self-test engine.
- Uses round-robin arbitration.
- Drives the full SETUP/ACCESS protocol for each granted transfer, including wait states.
- Returns read data and the error status to the winning requester.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 32, APB address width
DW, 32, APB data width
TO_CYC, 16, ACCESS-phase timeout in cycles (used only with the optional feature)

Ports:
i_clk  input  1  clock
i_presetn  input  1  asynchronous active-low reset
i_req  input  NREQ  per-requester transfer request, level, held until done
i_addr  input  NREQ*AW  per-requester address, requester k at [k*AW +: AW]
i_write  input  NREQ  per-requester direction, 1 = write
i_wdata  input  NREQ*DW  per-requester write data
o_gnt  output  NREQ  one-hot owner of the current transfer
o_done  output  NREQ  one-hot completion pulse
o_rdata  output  DW  read data, valid while any o_done bit is high
o_err  output  1  transfer error, valid while any o_done bit is high
o_paddr  output  AW  APB address
o_psel  output  1  APB select
o_penable  output  1  APB enable
o_pwrite  output  1  APB direction
o_pwdata  output  DW  APB write data
i_prdata  input  DW  APB read data
i_pready  input  1  APB ready
i_pslverr  input  1  APB slave error

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - All outputs go to 0; FSM goes to IDLE; round-robin pointer goes to 0.
  - The aborted transfer gets no done pulse.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any i_req bit is set, pick the winner by round-robin starting at the pointer.
  - Register the winner's index, addr, write and wdata into the o_p* registers.
  - Set o_gnt to the winner's bit and go to SETUP. Otherwise stay in IDLE.
- SETUP: o_psel=1, o_penable=0. Always goes to ACCESS on the next cycle.
- ACCESS: o_psel=1, o_penable=1.
  - If i_pready=0: stay in ACCESS. o_paddr, o_pwrite and o_pwdata are held stable.
  - If i_pready=1 (combinational in this cycle):
    - o_done[winner]=1, o_rdata=i_prdata, o_err=i_pslverr.
    - Next cycle: go to IDLE, clear o_gnt, set pointer to (winner+1) mod NREQ.
- o_rdata and o_err are 0 whenever o_done is 0.
- Minimum transfer: request sampled at edge 0; SETUP in cycle 1; ACCESS with done in cycle 2; IDLE in cycle 3. A new arbitration can happen in cycle 3.
- Requester rule:
  - Hold req and payload stable until its done pulse; deassert req in the cycle after done.
  - A req still high in the IDLE cycle after done is treated as a new request.
- Req dropped mid-transfer: ignored; the transfer completes and done still pulses.
- Simultaneous requests: the pointer gives fairness. With all requesters continuously requesting, grants rotate 0,1,..,NREQ-1,0.
- Write-then-read by the same requester is not reordered; exactly one transfer is outstanding.
- o_pwdata holds its last value on reads; it has no meaning on reads.

Optional Feature:
- Macro: ENCOUT_APB_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle with i_pready=0.
  - When it reaches TO_CYC, the FSM forces completion: o_done[winner]=1, o_err=1, o_rdata=0. Next cycle goes to IDLE with o_psel=0.
  - i_pready=1 in the same cycle the count reaches TO_CYC completes normally; ready wins.
- Undefined: no counter logic; ACCESS waits indefinitely for i_pready.

Decomposition:
- Package encout_apb_pkg:
  - State enum (IDLE, SETUP, ACCESS).
  - APB width constants (AW/DW defaults).
  - Default TO_CYC.
- Sub-module encout_rr_arb:
  - Combinational round-robin pick: inputs req vector and pointer; outputs one-hot grant and binary index.
  - The pointer register stays in the parent.

Test Plan:
1. Single write, i_pready=1: req0 with addr 0x0091_C100, wdata 0xA5 -> psel high for 2 cycles, penable in cycle 2 only, pwrite=1, pwdata=0xA5, o_done[0] in cycle 2, o_err=0.
2. Read with 3 wait states: req1 read 0x00D1_C700, i_prdata=0x1234_5678, pready low for 3 ACCESS cycles -> paddr stable throughout, o_done[1] on the 4th ACCESS cycle, o_rdata=0x1234_5678.
3. Contention: req0 and req1 high continuously for 6 transfers -> grant order 0,1,0,1,0,1, each transfer 3 cycles, no overlap of psel.
4. Slave error: i_pslverr=1 with pready -> o_err=1 only on the done cycle, then o_err=0.
5. Reset asserted in ACCESS -> o_psel, o_penable, o_gnt and o_done go to 0 immediately; after release, pending req0 is granted first (pointer=0).
6. With ENCOUT_APB_ARB_TIMEOUT_EN, TO_CYC=16, pready held 0 -> after 16 ACCESS cycles o_done=1, o_err=1, o_rdata=0, psel drops next cycle. Without the macro, ACCESS is held for 100 cycles and no done pulse occurs.

Source files
------------

// File: rtl/encout_apb_pkg.sv
// Shared types and defaults for the encoder-output APB arbiter.
// State encoding, APB width defaults and the default ACCESS timeout.
package encout_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_AW     = 32;
    localparam int APB_DW     = 32;
    localparam int DEF_TO_CYC = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/encout_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer.
// Produces a one-hot grant, its binary index and an any-request flag.
module encout_rr_arb
    import encout_apb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW:0] w_sum;
    logic [IW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int off = 0; off < NREQ; off++) begin
            // Candidate index wraps modulo NREQ, which need not be a power of two.
            w_sum = {1'b0, i_ptr} + (IW+1)'(off);
            if (w_sum >= (IW+1)'(NREQ))
                w_sum = w_sum - (IW+1)'(NREQ);
            w_cand = w_sum[IW-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/encout_apb_arb.sv
// APB3 master arbiter/sequencer sharing one APB bus among NREQ requesters.
// Optional ACCESS timeout enabled by defining ENCOUT_APB_ARB_TIMEOUT_EN.
module encout_apb_arb
    import encout_apb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int AW     = APB_AW,
    parameter int DW     = APB_DW,
    parameter int TO_CYC = DEF_TO_CYC
) (
    input  logic             i_clk,
    input  logic             i_presetn,
    input  logic [NREQ-1:0]  i_req,
    input  logic [NREQ*AW-1:0] i_addr,
    input  logic [NREQ-1:0]  i_write,
    input  logic [NREQ*DW-1:0] i_wdata,
    output logic [NREQ-1:0]  o_gnt,
    output logic [NREQ-1:0]  o_done,
    output logic [DW-1:0]    o_rdata,
    output logic             o_err,
    output logic [AW-1:0]    o_paddr,
    output logic             o_psel,
    output logic             o_penable,
    output logic             o_pwrite,
    output logic [DW-1:0]    o_pwdata,
    input  logic [DW-1:0]    i_prdata,
    input  logic             i_pready,
    input  logic             i_pslverr
);

    localparam int IW = idx_w(NREQ);

    apb_state_e r_state, w_state_nxt;
    logic [IW-1:0]   r_ptr, r_idx, w_ptr_nxt;
    logic [NREQ-1:0] r_gnt, w_arb_gnt;
    logic [IW-1:0]   w_arb_idx;
    logic            w_arb_any;
    logic [AW-1:0]   r_paddr, w_sel_addr;
    logic [DW-1:0]   r_pwdata, w_sel_wdata;
    logic            r_pwrite, w_sel_write;
    logic            w_timeout, w_complete;

    encout_rr_arb #(.NREQ(NREQ), .IW(IW)) u_rr (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_arb_idx == IW'(k)) begin
                w_sel_addr  = i_addr[k*AW +: AW];
                w_sel_wdata = i_wdata[k*DW +: DW];
                w_sel_write = i_write[k];
            end
        end
    end

`ifdef ENCOUT_APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);
    logic [CW-1:0] r_tocnt;

    // Counts unready ACCESS cycles; saturates at TO_CYC until the forced completion.
    always_ff @(posedge i_clk or negedge i_presetn) begin
        if (!i_presetn)
            r_tocnt <= '0;
        else if (r_state == ST_SETUP)
            r_tocnt <= '0;
        else if (r_state == ST_ACCESS && !i_pready && r_tocnt != CW'(TO_CYC))
            r_tocnt <= r_tocnt + 1'b1;
    end

    assign w_timeout = (r_state == ST_ACCESS) && (r_tocnt == CW'(TO_CYC));
`else
    logic w_unused_to;
    assign w_unused_to = (TO_CYC == 0);
    assign w_timeout   = 1'b0;
`endif

    assign w_ptr_nxt = (r_idx == IW'(NREQ-1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge i_clk or negedge i_presetn) begin
        if (!i_presetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        o_psel      = 1'b0;
        o_penable   = 1'b0;
        o_done      = '0;
        o_rdata     = '0;
        o_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any)
                    w_state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                o_psel      = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                o_psel    = 1'b1;
                o_penable = 1'b1;
                // Ready takes priority over a timeout that lands in the same cycle.
                if (i_pready || w_timeout) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    o_done      = r_gnt;
                    o_rdata     = i_pready ? i_prdata : '0;
                    o_err       = i_pready ? i_pslverr : 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_ptr    <= '0;
            r_idx    <= '0;
            r_gnt    <= '0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else if (r_state == ST_IDLE && w_arb_any) begin
            r_idx    <= w_arb_idx;
            r_gnt    <= w_arb_gnt;
            r_paddr  <= w_sel_addr;
            r_pwrite <= w_sel_write;
            if (w_sel_write)
                r_pwdata <= w_sel_wdata;
        end else if (w_complete) begin
            r_gnt <= '0;
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_gnt    = r_gnt;
    assign o_paddr  = r_paddr;
    assign o_pwrite = r_pwrite;
    assign o_pwdata = r_pwdata;

endmodule

// File: tb/tb_encout_apb_arb.sv
// Directed bench for encout_apb_arb: vector table of single transfers plus
// hand sequences for reset-in-ACCESS, contention and the ACCESS timeout.
module tb_encout_apb_arb;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              presetn;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]   wr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   gnt, done;
    logic [DW-1:0]     rdata;
    logic              err;
    logic [AW-1:0]     paddr;
    logic              psel, penable, pwrite;
    logic [DW-1:0]     pwdata;
    logic [DW-1:0]     prdata;
    logic              pready, pslverr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] last_wd = '0;

    typedef struct {
        int          k;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic        serr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    encout_apb_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TO_CYC(16)) dut (
        .i_clk     (clk),
        .i_presetn (presetn),
        .i_req     (req),
        .i_addr    (addr),
        .i_write   (wr),
        .i_wdata   (wdata),
        .o_gnt     (gnt),
        .o_done    (done),
        .o_rdata   (rdata),
        .o_err     (err),
        .o_paddr   (paddr),
        .o_psel    (psel),
        .o_penable (penable),
        .o_pwrite  (pwrite),
        .o_pwdata  (pwdata),
        .i_prdata  (prdata),
        .i_pready  (pready),
        .i_pslverr (pslverr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        logic [NREQ-1:0] eg;
        logic [DW-1:0]   epw;
        eg = '0;
        eg[v.k] = 1'b1;
        if (v.wr) last_wd = v.wdata;
        epw = last_wd;
        req[v.k] = 1'b1;
        addr[v.k*AW +: AW] = v.addr;
        wr[v.k] = v.wr;
        wdata[v.k*DW +: DW] = v.wdata;
        prdata = v.prdata;
        pready = 1'b0;
        pslverr = 1'b0;
        @(posedge clk); #1;
        check("setup_gnt", gnt, eg);
        check("setup_psel", {psel, penable}, 2'b10);
        check("setup_paddr", paddr, v.addr);
        check("setup_pwrite", pwrite, v.wr);
        check("setup_pwdata", pwdata, epw);
        check("setup_done", done, 0);
        for (int w = 0; w < v.waits; w++) begin
            @(posedge clk); #1;
            check("wait_penable", {psel, penable}, 2'b11);
            check("wait_done", done, 0);
            check("wait_rdata", {err, rdata}, 0);
            check("wait_paddr", paddr, v.addr);
        end
        @(posedge clk); #1;
        pready = 1'b1;
        pslverr = v.serr;
        #1;
        check("acc_penable", {psel, penable}, 2'b11);
        check("acc_done", done, eg);
        check("acc_rdata", rdata, v.exp_rdata);
        check("acc_err", err, v.exp_err);
        @(posedge clk); #1;
        req[v.k] = 1'b0;
        pready = 1'b0;
        pslverr = 1'b0;
        #1;
        check("idle_psel", {psel, penable}, 2'b00);
        check("idle_gnt", gnt, 0);
        check("idle_done_err", {done, err}, 0);
        check("idle_rdata", rdata, 0);
    endtask

    initial begin
        vecs[0] = '{k:0, wr:1'b1, addr:32'h0091_C100, wdata:32'h0000_00A5, prdata:32'h0,
                    waits:0, serr:1'b0, exp_rdata:32'h0, exp_err:1'b0};
        vecs[1] = '{k:1, wr:1'b0, addr:32'h00D1_C700, wdata:32'h0, prdata:32'h1234_5678,
                    waits:3, serr:1'b0, exp_rdata:32'h1234_5678, exp_err:1'b0};
        vecs[2] = '{k:0, wr:1'b0, addr:32'h0091_C104, wdata:32'h0, prdata:32'hDEAD_BEEF,
                    waits:1, serr:1'b1, exp_rdata:32'hDEAD_BEEF, exp_err:1'b1};
        vecs[3] = '{k:1, wr:1'b1, addr:32'h00D1_C708, wdata:32'hCAFE_F00D, prdata:32'h0,
                    waits:2, serr:1'b0, exp_rdata:32'h0, exp_err:1'b0};
        vecs[4] = '{k:0, wr:1'b1, addr:32'h0091_C10C, wdata:32'h0BAD_0001, prdata:32'h0,
                    waits:0, serr:1'b1, exp_rdata:32'h0, exp_err:1'b1};

        presetn = 1'b0;
        req = '0; addr = '0; wr = '0; wdata = '0;
        prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {psel, penable, pwrite, err}, 0);
        check("rst_gnt_done", {gnt, done}, 0);
        check("rst_paddr", paddr, 0);
        check("rst_data", {pwdata, rdata}, 0);
        presetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++)
            run_xfer(vecs[i]);

        // Reset while requester 1 sits in ACCESS; pointer is 1 at this point.
        req[1] = 1'b1;
        addr[1*AW +: AW] = 32'h00D1_C710;
        wr[1] = 1'b0;
        prdata = 32'h7777_7777;
        @(posedge clk); #1;
        check("rst_seq_gnt1", gnt, 2'b10);
        @(posedge clk); #1;
        check("rst_seq_access", {psel, penable}, 2'b11);
        req[0] = 1'b1;
        addr[0*AW +: AW] = 32'h0091_C200;
        wr[0] = 1'b0;
        #1;
        presetn = 1'b0;
        #1;
        check("rst_seq_psel", {psel, penable}, 2'b00);
        check("rst_seq_gnt_done", {gnt, done}, 0);
        @(posedge clk); #1;
        check("rst_seq_hold", {psel, gnt, done}, 0);
        presetn = 1'b1;
        pready = 1'b1;

        // Both requesters held high: grants must alternate starting at 0.
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            check("cont_setup_gnt", gnt, (t % 2 == 0) ? 2'b01 : 2'b10);
            check("cont_setup_psel", {psel, penable}, 2'b10);
            @(posedge clk); #1;
            check("cont_done", done, (t % 2 == 0) ? 2'b01 : 2'b10);
            check("cont_rdata", rdata, 32'h7777_7777);
            @(posedge clk); #1;
            check("cont_idle_psel", psel, 1'b0);
            if (t == 5) req = '0;
        end

        // Stalled slave: pointer is back at 0.
        pready = 1'b0;
        prdata = 32'h0000_FEED;
        req[0] = 1'b1;
        @(posedge clk); #1;
        check("stall_setup_gnt", gnt, 2'b01);
`ifdef ENCOUT_APB_ARB_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            check("to_wait_done", done, 0);
        end
        @(posedge clk); #1;
        check("to_done", done, 2'b01);
        check("to_err", err, 1'b1);
        check("to_rdata", rdata, 0);
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("to_psel_drop", psel, 1'b0);
`else
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            check("stall_done", done, 0);
            check("stall_access", {psel, penable}, 2'b11);
        end
        pready = 1'b1;
        #1;
        check("stall_release_done", done, 2'b01);
        check("stall_release_rdata", rdata, 32'h0000_FEED);
        @(posedge clk); #1;
        req[0] = 1'b0;
        pready = 1'b0;
        #1;
        check("stall_idle_psel", psel, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
